// File: rtl/opc_bus_pkg.sv
// +----------------------------------------------------------------------+
// | opc_bus_pkg : shared state encoding, region constants, region decode  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package opc_bus_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_RAM  = 2'd1,
    REG_PROG = 2'd2,
    REG_IO   = 2'd3
  } region_t;

  localparam logic [10:0] DEFAULT_PROG_BASE = 11'h100;
  localparam logic [10:0] DEFAULT_IO_ADDR   = 11'h7FF;

  // Operands are widened to 32 bits so the range sum cannot overflow.
  function automatic region_t decode_region(
    input logic [31:0] addr,
    input logic [31:0] ram_depth,
    input logic [31:0] prog_base,
    input logic [31:0] prog_depth,
    input logic [31:0] io_addr
  );
    region_t result;
    if (addr == io_addr)
      result = REG_IO;
    else if (addr < ram_depth)
      result = REG_RAM;
    else if ((addr >= prog_base) && (addr < (prog_base + prog_depth)))
      result = REG_PROG;
    else
      result = REG_NONE;
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/opc_bus_loader.sv
// +----------------------------------------------------------------------+
// | opc_bus_loader : LOAD/RELEASE/RUN sequencer and program-store filler  |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module opc_bus_loader #(
  parameter int PROG_DEPTH = 64,
  parameter int DATA_W     = 8,
  parameter int PTR_W      = $clog2(PROG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              reload,
  output logic              load_ready,
  output logic              cpu_rst_n,
  output logic              run,
  output logic              to_load,
  output logic              prog_we,
  output logic [PTR_W-1:0]  prog_waddr,
  output logic [DATA_W-1:0] prog_wdata
);
  import opc_bus_pkg::*;

  state_t           state;
  state_t           state_next;
  logic [PTR_W-1:0] load_ptr;
  logic [PTR_W-1:0] load_ptr_next;
  logic             accept;

  assign accept     = load_valid && load_ready;
  assign run        = (state == ST_RUN);
  assign to_load    = (state == ST_RUN) && reload;
  assign prog_waddr = load_ptr;
  assign prog_wdata = load_data;

  always_comb begin
    state_next    = state;
    load_ptr_next = load_ptr;
    prog_we       = 1'b0;
    case (state)
      ST_LOAD: begin
        if (accept) begin
          // A reset in the same cycle must not leave a stray byte behind.
          prog_we = !rst;
          if (load_last || (load_ptr == PTR_W'(PROG_DEPTH - 1)))
            state_next = ST_RELEASE;
          else
            load_ptr_next = load_ptr + PTR_W'(1);
        end
      end
      ST_RELEASE: state_next = ST_RUN;
      ST_RUN: begin
        if (reload) begin
          state_next    = ST_LOAD;
          load_ptr_next = '0;
        end
      end
      default: begin
        state_next    = ST_LOAD;
        load_ptr_next = '0;
      end
    endcase
  end

  // Handshake outputs are registered from next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LOAD;
      load_ptr   <= '0;
      cpu_rst_n  <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state      <= state_next;
      load_ptr   <= load_ptr_next;
      cpu_rst_n  <= (state_next == ST_RUN);
      load_ready <= (state_next == ST_LOAD);
    end
  end

endmodule

`default_nettype wire

// File: rtl/opc_bus_responder.sv
// +----------------------------------------------------------------------+
// | opc_bus_responder : OPC bus target - scratch RAM, program store, IO   |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module opc_bus_responder #(
  parameter int                ADDR_W     = 11,
  parameter int                DATA_W     = 8,
  parameter int                RAM_DEPTH  = 64,
  parameter logic [ADDR_W-1:0] PROG_BASE  = opc_bus_pkg::DEFAULT_PROG_BASE,
  parameter int                PROG_DEPTH = 64,
  parameter logic [ADDR_W-1:0] IO_ADDR    = opc_bus_pkg::DEFAULT_IO_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              rnw,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              cpu_rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  output logic [DATA_W-1:0] io_data,
  output logic              io_strobe,
  output logic              bus_err
);
  import opc_bus_pkg::*;

  localparam int RAM_AW  = $clog2(RAM_DEPTH);
  localparam int PROG_AW = $clog2(PROG_DEPTH);

  logic [DATA_W-1:0]  ram  [RAM_DEPTH];
  logic [DATA_W-1:0]  prog [PROG_DEPTH];

  region_t            region;
  logic [RAM_AW-1:0]  ram_idx;
  logic [PROG_AW-1:0] prog_idx;
  logic               run;
  logic               to_load;
  logic               wr_en;
  logic               prog_we;
  logic [PROG_AW-1:0] prog_waddr;
  logic [DATA_W-1:0]  prog_wdata;

  opc_bus_loader #(
    .PROG_DEPTH (PROG_DEPTH),
    .DATA_W     (DATA_W),
    .PTR_W      (PROG_AW)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .reload     (reload),
    .load_ready (load_ready),
    .cpu_rst_n  (cpu_rst_n),
    .run        (run),
    .to_load    (to_load),
    .prog_we    (prog_we),
    .prog_waddr (prog_waddr),
    .prog_wdata (prog_wdata)
  );

  assign region = decode_region(32'(address), 32'(RAM_DEPTH), 32'(PROG_BASE),
                                32'(PROG_DEPTH), 32'(IO_ADDR));

  // Offsets are truncated only after the region check has qualified them.
  assign ram_idx  = RAM_AW'(address);
  assign prog_idx = PROG_AW'(address - PROG_BASE);
  assign wr_en    = run && !rnw && !rst;

  always_comb begin
    rdata = '0;
    case (region)
      REG_RAM:  rdata = ram[ram_idx];
      REG_PROG: rdata = prog[prog_idx];
      REG_IO:   rdata = io_data;
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && (region == REG_RAM))
      ram[ram_idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (prog_we)
      prog[prog_waddr] <= prog_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_data   <= '0;
      io_strobe <= 1'b0;
    end else begin
      io_strobe <= wr_en && (region == REG_IO);
      if (wr_en && (region == REG_IO))
        io_data <= wdata;
    end
  end

  // Sticky until reset or a return to LOAD; the clear wins over a same-cycle error.
  always_ff @(posedge clk) begin
    if (rst || to_load)
      bus_err <= 1'b0;
    else if (wr_en && ((region == REG_PROG) || (region == REG_NONE)))
      bus_err <= 1'b1;
  end

endmodule

`default_nettype wire

// File: tb/tb_opc_bus_responder.sv
// +----------------------------------------------------------------------+
// | tb_opc_bus_responder : self-checking bench for opc_bus_responder      |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_opc_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] address;
  logic        rnw;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        cpu_rst_n;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        reload;
  logic [7:0]  io_data;
  logic        io_strobe;
  logic        bus_err;

  int          compared   = 0;
  int          mismatched = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp;

  opc_bus_responder dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .rnw        (rnw),
    .wdata      (wdata),
    .rdata      (rdata),
    .cpu_rst_n  (cpu_rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .reload     (reload),
    .io_data    (io_data),
    .io_strobe  (io_strobe),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rnw        = 1'b1;
    wdata      = 8'h00;
    address    = 11'h000;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
    reload     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    compared++;
    if (cpu_rst_n !== 1'b0) begin
      mismatched++; $display("FAIL reset_cpu_rst_n: got %b want 0", cpu_rst_n);
    end
    compared++;
    if (load_ready !== 1'b1) begin
      mismatched++; $display("FAIL reset_load_ready: got %b want 1", load_ready);
    end
    compared++;
    if ({io_data, io_strobe, bus_err} !== 10'h000) begin
      mismatched++;
      $display("FAIL reset_outputs: io_data=%h io_strobe=%b bus_err=%b want 00/0/0",
               io_data, io_strobe, bus_err);
    end
    address = 11'h7FF;
    #1;
    compared++;
    if (rdata !== 8'h00) begin
      mismatched++; $display("FAIL reset_io_read: got %h want 00", rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_load();
    logic [7:0] beats [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = beats[i];
      load_last  = (i == 3);
      exp_q.push_back(beats[i]);
      #1;
      compared++;
      if ({load_ready, cpu_rst_n} !== 2'b10) begin
        mismatched++;
        $display("FAIL load_beat%0d_hs: ready=%b cpu_rst_n=%b want 1/0", i, load_ready, cpu_rst_n);
      end
      tick();
    end
    idle_inputs();
    compared++;
    if ({load_ready, cpu_rst_n} !== 2'b00) begin
      mismatched++;
      $display("FAIL release_hs: ready=%b cpu_rst_n=%b want 0/0", load_ready, cpu_rst_n);
    end
    tick();
    compared++;
    if ({load_ready, cpu_rst_n} !== 2'b01) begin
      mismatched++;
      $display("FAIL run_hs: ready=%b cpu_rst_n=%b want 0/1", load_ready, cpu_rst_n);
    end
    for (int i = 0; i < 4; i++) begin
      address = 11'h100 + 11'(i);
      #1;
      exp = exp_q.pop_front();
      compared++;
      if (rdata !== exp) begin
        mismatched++; $display("FAIL prog_read_%0d: got %h want %h", i, rdata, exp);
      end
    end
  endtask

  task automatic test_ram();
    address = 11'h010; rnw = 1'b0; wdata = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    address = 11'h03F; wdata = 8'h7E;
    exp_q.push_back(8'h7E);
    tick();
    rnw = 1'b1;
    address = 11'h010;
    #1;
    exp = exp_q.pop_front();
    compared++;
    if (rdata !== exp) begin
      mismatched++; $display("FAIL ram_read_010: got %h want %h", rdata, exp);
    end
    address = 11'h03F;
    #1;
    exp = exp_q.pop_front();
    compared++;
    if (rdata !== exp) begin
      mismatched++; $display("FAIL ram_read_03F: got %h want %h", rdata, exp);
    end
    address = 11'h040;
    #1;
    compared++;
    if (rdata !== 8'h00) begin
      mismatched++; $display("FAIL unmapped_read_040: got %h want 00", rdata);
    end
    compared++;
    if (bus_err !== 1'b0) begin
      mismatched++; $display("FAIL ram_bus_err: got %b want 0", bus_err);
    end
  endtask

  task automatic test_back_to_back_io();
    address = 11'h7FF; rnw = 1'b0; wdata = 8'h5A;
    exp_q.push_back(8'h5A);
    tick();
    exp = exp_q.pop_front();
    compared++;
    if ({io_strobe, io_data} !== {1'b1, exp}) begin
      mismatched++; $display("FAIL io_first: strobe=%b data=%h want 1/%h", io_strobe, io_data, exp);
    end
    wdata = 8'h3C;
    exp_q.push_back(8'h3C);
    tick();
    exp = exp_q.pop_front();
    compared++;
    if ({io_strobe, io_data} !== {1'b1, exp}) begin
      mismatched++; $display("FAIL io_second: strobe=%b data=%h want 1/%h", io_strobe, io_data, exp);
    end
    rnw = 1'b1;
    tick();
    compared++;
    if (io_strobe !== 1'b0) begin
      mismatched++; $display("FAIL io_strobe_drop: got %b want 0", io_strobe);
    end
    compared++;
    if (rdata !== 8'h3C) begin
      mismatched++; $display("FAIL io_read: got %h want 3c", rdata);
    end
  endtask

  task automatic test_illegal();
    address = 11'h100; rnw = 1'b0; wdata = 8'hFF;
    tick();
    rnw = 1'b1;
    #1;
    compared++;
    if (bus_err !== 1'b1) begin
      mismatched++; $display("FAIL err_prog_write: got %b want 1", bus_err);
    end
    compared++;
    if (rdata !== 8'h11) begin
      mismatched++; $display("FAIL prog0_unchanged: got %h want 11", rdata);
    end
    address = 11'h400; rnw = 1'b0; wdata = 8'h00;
    tick();
    rnw = 1'b1;
    tick();
    compared++;
    if (bus_err !== 1'b1) begin
      mismatched++; $display("FAIL err_sticky: got %b want 1", bus_err);
    end
    reload = 1'b1;
    tick();
    reload = 1'b0;
    compared++;
    if ({cpu_rst_n, bus_err, load_ready} !== 3'b001) begin
      mismatched++;
      $display("FAIL reload: cpu_rst_n=%b bus_err=%b ready=%b want 0/0/1", cpu_rst_n, bus_err, load_ready);
    end
    // Writes while loading are ignored, including illegal and IO targets.
    address = 11'h400; rnw = 1'b0;
    tick();
    address = 11'h010; wdata = 8'h00;
    tick();
    address = 11'h7FF; wdata = 8'hEE;
    tick();
    rnw = 1'b1;
    compared++;
    if ({bus_err, io_strobe, io_data} !== {2'b00, 8'h3C}) begin
      mismatched++;
      $display("FAIL load_writes_ignored: err=%b strobe=%b io=%h want 0/0/3c", bus_err, io_strobe, io_data);
    end
    address = 11'h010;
    #1;
    compared++;
    if (rdata !== 8'hA5) begin
      mismatched++; $display("FAIL ram_kept_in_load: got %h want a5", rdata);
    end
  endtask

  task automatic test_priority();
    load_valid = 1'b1; load_data = 8'hC1;
    tick();
    load_data = 8'hC2;
    tick();
    rst = 1'b1; reload = 1'b1; load_data = 8'hEE;
    tick();
    rst = 1'b0; reload = 1'b0; load_valid = 1'b0;
    compared++;
    if ({cpu_rst_n, load_ready} !== 2'b01) begin
      mismatched++; $display("FAIL prio_state: cpu_rst_n=%b ready=%b want 0/1", cpu_rst_n, load_ready);
    end
    address = 11'h102;
    #1;
    compared++;
    if (rdata !== 8'h33) begin
      mismatched++; $display("FAIL prio_beat_dropped: got %h want 33", rdata);
    end
    load_valid = 1'b1; load_data = 8'hD0; load_last = 1'b1;
    tick();
    idle_inputs();
    address = 11'h100;
    #1;
    compared++;
    if (rdata !== 8'hD0) begin
      mismatched++; $display("FAIL prio_ptr_zero: got %h want d0", rdata);
    end
    address = 11'h101;
    #1;
    compared++;
    if (rdata !== 8'hC2) begin
      mismatched++; $display("FAIL prio_prog1: got %h want c2", rdata);
    end
    tick();
    compared++;
    if (cpu_rst_n !== 1'b1) begin
      mismatched++; $display("FAIL prio_run: cpu_rst_n=%b want 1", cpu_rst_n);
    end
  endtask

  task automatic test_full_load();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(i * 3 + 1);
      exp_q.push_back(8'(i * 3 + 1));
      tick();
    end
    load_data = 8'h99;
    compared++;
    if ({load_ready, cpu_rst_n} !== 2'b00) begin
      mismatched++; $display("FAIL full_release: ready=%b cpu_rst_n=%b want 0/0", load_ready, cpu_rst_n);
    end
    tick();
    tick();
    load_valid = 1'b0;
    compared++;
    if ({load_ready, cpu_rst_n} !== 2'b01) begin
      mismatched++; $display("FAIL full_run: ready=%b cpu_rst_n=%b want 0/1", load_ready, cpu_rst_n);
    end
    for (int i = 0; i < 64; i++) begin
      address = 11'h100 + 11'(i);
      #1;
      exp = exp_q.pop_front();
      compared++;
      if (rdata !== exp) begin
        mismatched++; $display("FAIL full_read_%0d: got %h want %h", i, rdata, exp);
      end
    end
    address = 11'h140;
    #1;
    compared++;
    if (rdata !== 8'h00) begin
      mismatched++; $display("FAIL read_past_prog: got %h want 00", rdata);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_reset_load();
    test_ram();
    test_back_to_back_io();
    test_illegal();
    test_priority();
    test_full_load();
    compared++;
    if (exp_q.size() !== 0) begin
      mismatched++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
